// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core: execute command encodings,
// default widths and the ID/EX control bundle.
package core_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT     = 32;
  localparam int unsigned REG_ADDR_WIDTH_DEFAULT = 4;

  typedef enum logic [3:0] {
    EXE_CMD_NOP = 4'b0000,
    EXE_CMD_MOV = 4'b0001,
    EXE_CMD_ADD = 4'b0010,
    EXE_CMD_ADC = 4'b0011,
    EXE_CMD_SUB = 4'b0100,
    EXE_CMD_SBC = 4'b0101,
    EXE_CMD_AND = 4'b0110,
    EXE_CMD_ORR = 4'b0111,
    EXE_CMD_EOR = 4'b1000,
    EXE_CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef struct packed {
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     b;
    logic     s;
    exe_cmd_e exe_cmd;
  } id_ex_ctrl_t;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline flop bank: async reset, synchronous clear, enable (hold).
// Clear wins over enable so a flush is never swallowed by a stall.
module pipe_reg_en_clr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: control bundle (with valid) and datapath bundle,
// supporting hazard freeze and branch flush.
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic                      wb_en_in,
  input  logic                      mem_r_en_in,
  input  logic                      mem_w_en_in,
  input  logic                      b_in,
  input  logic                      s_in,
  input  logic [3:0]                exe_cmd_in,
  input  logic [DATA_WIDTH-1:0]     pc_in,
  input  logic [DATA_WIDTH-1:0]     val_rn_in,
  input  logic [DATA_WIDTH-1:0]     val_rm_in,
  input  logic                      imm_in,
  input  logic [11:0]               shift_operand_in,
  input  logic [23:0]               signed_imm_24_in,
  input  logic [REG_ADDR_WIDTH-1:0] dest_in,
  input  logic [REG_ADDR_WIDTH-1:0] src1_in,
  input  logic [REG_ADDR_WIDTH-1:0] src2_in,
  input  logic [3:0]                status_in,
  output logic                      valid_out,
  output logic                      wb_en_out,
  output logic                      mem_r_en_out,
  output logic                      mem_w_en_out,
  output logic                      b_out,
  output logic                      s_out,
  output logic [3:0]                exe_cmd_out,
  output logic [DATA_WIDTH-1:0]     pc_out,
  output logic [DATA_WIDTH-1:0]     val_rn_out,
  output logic [DATA_WIDTH-1:0]     val_rm_out,
  output logic                      imm_out,
  output logic [11:0]               shift_operand_out,
  output logic [23:0]               signed_imm_24_out,
  output logic [REG_ADDR_WIDTH-1:0] dest_out,
  output logic [REG_ADDR_WIDTH-1:0] src1_out,
  output logic [REG_ADDR_WIDTH-1:0] src2_out,
  output logic [3:0]                status_out
);

  localparam int unsigned CTRL_W = $bits(id_ex_ctrl_t) + 1;
  localparam int unsigned DATA_W = 3 * DATA_WIDTH + 1 + 12 + 24
                                   + 3 * REG_ADDR_WIDTH + 4;

  id_ex_ctrl_t            ctrl_d;
  id_ex_ctrl_t            ctrl_q;
  logic                   valid_q;
  logic [CTRL_W-1:0]      ctrl_bank_q;
  logic [DATA_W-1:0]      data_d;
  logic [DATA_W-1:0]      data_q;
  logic                   capture_en;
  logic                   ctrl_clr;

  always_comb begin
    ctrl_d          = '0;
    ctrl_d.wb_en    = wb_en_in;
    ctrl_d.mem_r_en = mem_r_en_in;
    ctrl_d.mem_w_en = mem_w_en_in;
    ctrl_d.b        = b_in;
    ctrl_d.s        = s_in;
    ctrl_d.exe_cmd  = exe_cmd_e'(exe_cmd_in);
  end

  assign capture_en = ~freeze;
  // Invalid-capture clear is gated by freeze so a stall holds a live instruction.
  assign ctrl_clr   = flush | (~valid_in & ~freeze);

  pipe_reg_en_clr #(
    .WIDTH(CTRL_W)
  ) u_ctrl_reg (
    .clk(clk),
    .rst(rst),
    .en (capture_en),
    .clr(ctrl_clr),
    .d  ({valid_in, ctrl_d}),
    .q  (ctrl_bank_q)
  );

  assign {valid_q, ctrl_q} = ctrl_bank_q;

  assign data_d = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                   signed_imm_24_in, dest_in, src1_in, src2_in, status_in};

  pipe_reg_en_clr #(
    .WIDTH(DATA_W)
  ) u_data_reg (
    .clk(clk),
    .rst(rst),
    .en (capture_en),
    .clr(flush),
    .d  (data_d),
    .q  (data_q)
  );

  assign valid_out    = valid_q;
  assign wb_en_out    = ctrl_q.wb_en;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;
  assign b_out        = ctrl_q.b;
  assign s_out        = ctrl_q.s;
  assign exe_cmd_out  = ctrl_q.exe_cmd;

  assign {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
          signed_imm_24_out, dest_out, src1_out, src2_out, status_out} = data_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: expected outputs are queued as
// stimulus is applied and compared one edge later.
module tb_id_ex_stage_reg;
  import core_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic [3:0]  cmd;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  st;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  sb_t  cur_in = '0;
  sb_t  obs;
  sb_t  model = '0;
  sb_t  q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .valid_in(cur_in.valid), .wb_en_in(cur_in.wb), .mem_r_en_in(cur_in.mr),
    .mem_w_en_in(cur_in.mw), .b_in(cur_in.b), .s_in(cur_in.s),
    .exe_cmd_in(cur_in.cmd), .pc_in(cur_in.pc), .val_rn_in(cur_in.rn),
    .val_rm_in(cur_in.rm), .imm_in(cur_in.imm), .shift_operand_in(cur_in.sh),
    .signed_imm_24_in(cur_in.si), .dest_in(cur_in.dest), .src1_in(cur_in.s1),
    .src2_in(cur_in.s2), .status_in(cur_in.st),
    .valid_out(obs.valid), .wb_en_out(obs.wb), .mem_r_en_out(obs.mr),
    .mem_w_en_out(obs.mw), .b_out(obs.b), .s_out(obs.s),
    .exe_cmd_out(obs.cmd), .pc_out(obs.pc), .val_rn_out(obs.rn),
    .val_rm_out(obs.rm), .imm_out(obs.imm), .shift_operand_out(obs.sh),
    .signed_imm_24_out(obs.si), .dest_out(obs.dest), .src1_out(obs.s1),
    .src2_out(obs.s2), .status_out(obs.st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic sb_t model_next(input sb_t cur, input sb_t in_v,
                                     input logic fl, input logic fz);
    sb_t n;
    if (fl) begin
      n = '0;
    end else if (fz) begin
      n = cur;
    end else begin
      n = in_v;
      if (!in_v.valid) begin
        n.wb = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.b = 1'b0; n.s = 1'b0;
        n.cmd = 4'b0000;
      end
    end
    return n;
  endfunction

  task automatic compare_all(input string ctx, input sb_t e);
    check({ctx, ".valid"}, 32'(obs.valid), 32'(e.valid));
    check({ctx, ".wb_en"}, 32'(obs.wb), 32'(e.wb));
    check({ctx, ".mem_r"}, 32'(obs.mr), 32'(e.mr));
    check({ctx, ".mem_w"}, 32'(obs.mw), 32'(e.mw));
    check({ctx, ".b"}, 32'(obs.b), 32'(e.b));
    check({ctx, ".s"}, 32'(obs.s), 32'(e.s));
    check({ctx, ".exe_cmd"}, 32'(obs.cmd), 32'(e.cmd));
    check({ctx, ".pc"}, obs.pc, e.pc);
    check({ctx, ".val_rn"}, obs.rn, e.rn);
    check({ctx, ".val_rm"}, obs.rm, e.rm);
    check({ctx, ".imm"}, 32'(obs.imm), 32'(e.imm));
    check({ctx, ".shift_op"}, 32'(obs.sh), 32'(e.sh));
    check({ctx, ".simm24"}, 32'(obs.si), 32'(e.si));
    check({ctx, ".dest"}, 32'(obs.dest), 32'(e.dest));
    check({ctx, ".src1"}, 32'(obs.s1), 32'(e.s1));
    check({ctx, ".src2"}, 32'(obs.s2), 32'(e.s2));
    check({ctx, ".status"}, 32'(obs.st), 32'(e.st));
    check({ctx, ".rw_excl"}, 32'(obs.mr & obs.mw), 32'd0);
    check({ctx, ".bubble_ctrl"},
          32'(!obs.valid && (obs.wb || obs.mr || obs.mw || obs.b || obs.s || obs.cmd != 4'd0)),
          32'd0);
  endtask

  task automatic step(input string ctx);
    sb_t e;
    e = model_next(model, cur_in, flush, freeze);
    model = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    compare_all(ctx, q.pop_front());
  endtask

  function automatic sb_t rand_in();
    sb_t r;
    int unsigned mem_op;
    r.valid = ($urandom_range(0, 9) < 8);
    mem_op  = $urandom_range(0, 2);
    r.mr    = (mem_op == 1);
    r.mw    = (mem_op == 2);
    r.wb    = 1'($urandom);
    r.b     = 1'($urandom);
    r.s     = 1'($urandom);
    r.cmd   = 4'($urandom_range(0, 9));
    r.pc    = $urandom;
    r.rn    = $urandom;
    r.rm    = $urandom;
    r.imm   = 1'($urandom);
    r.sh    = 12'($urandom);
    r.si    = 24'($urandom);
    r.dest  = 4'($urandom);
    r.s1    = 4'($urandom);
    r.s2    = 4'($urandom);
    r.st    = 4'($urandom);
    return r;
  endfunction

  initial begin
    sb_t zero = '0;
    sb_t t;

    #1;
    compare_all("reset_init", zero);
    @(negedge clk);
    rst = 1'b0;

    // Normal capture of an ADD
    t = '0; t.valid = 1'b1; t.wb = 1'b1; t.cmd = EXE_CMD_ADD;
    t.rn = 32'h0000_0005; t.dest = 4'd3; t.pc = 32'h0000_0104;
    cur_in = t;
    step("capture");
    check("capture.dest_direct", 32'(obs.dest), 32'd3);

    // Freeze for 3 cycles while inputs change to SUB / R7
    freeze = 1'b1;
    t.cmd = EXE_CMD_SUB; t.dest = 4'd7; t.rn = 32'h0000_0099;
    cur_in = t;
    for (int unsigned i = 0; i < 3; i++) begin
      step("freeze");
      check("freeze.cmd_held", 32'(obs.cmd), 32'(EXE_CMD_ADD));
    end
    freeze = 1'b0;
    step("unfreeze");
    check("unfreeze.dest_new", 32'(obs.dest), 32'd7);

    // LDR hit by flush and freeze together
    t = '0; t.valid = 1'b1; t.wb = 1'b1; t.mr = 1'b1; t.cmd = EXE_CMD_ADD;
    t.dest = 4'd9; t.pc = 32'h0000_0200;
    cur_in = t;
    flush = 1'b1; freeze = 1'b1;
    step("flush_freeze");
    flush = 1'b0; freeze = 1'b0;

    // Bubble invariant: invalid capture drops control, keeps datapath
    t = '0; t.valid = 1'b0; t.mw = 1'b1; t.cmd = EXE_CMD_ADD;
    t.rm = 32'hDEAD_BEEF; t.dest = 4'd5;
    cur_in = t;
    step("bubble");

    // Back-to-back flushes on valid instructions
    t = '0; t.valid = 1'b1; t.wb = 1'b1; t.b = 1'b1; t.cmd = EXE_CMD_MOV;
    t.dest = 4'd2; t.si = 24'hABCDEF;
    cur_in = t;
    step("pre_flush");
    flush = 1'b1;
    step("flush1");
    step("flush2");
    flush = 1'b0;
    step("post_flush");

    // Async reset between edges with nonzero outputs
    #2;
    rst = 1'b1;
    #1;
    compare_all("reset_async", zero);
    model = '0;
    @(negedge clk);
    rst = 1'b0;
    step("post_reset");

    // Random stream with random freeze/flush
    for (int unsigned i = 0; i < 400; i++) begin
      cur_in = rand_in();
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 6) == 0);
      step("rand");
    end
    freeze = 1'b0;
    flush  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
